// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard unit bundle: datapath-side pipeline state in,
// stall/flush/forward controls and MDU status out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  rs_d;
  logic [REG_W-1:0]  rt_d;
  logic [REG_W-1:0]  rs_e;
  logic [REG_W-1:0]  rt_e;
  logic [REG_W-1:0]  write_reg_e;
  logic [REG_W-1:0]  write_reg_m;
  logic [REG_W-1:0]  write_reg_wb;
  logic              reg_write_e;
  logic              reg_write_m;
  logic              reg_write_wb;
  logic [1:0]        mem_to_reg_e;
  logic [1:0]        mem_to_reg_m;
  logic [2:0]        branch_d;
  logic [1:0]        jump_d;
  logic              link_d;
  logic              hilo_d;
  logic              md_start_e;
  logic              md_div_e;
  logic              perf_clr;
  logic              stall_f;
  logic              stall_d;
  logic              flush_e;
  logic              forwardA_d;
  logic              forwardB_d;
  logic [1:0]        forwardA_e;
  logic [1:0]        forwardB_e;
  logic              forward_jr_f;
  logic              forward_jalr_f;
  logic              md_busy;
  logic              md_done;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, rs_e, rt_e,
    output write_reg_e, write_reg_m, write_reg_wb,
    output reg_write_e, reg_write_m, reg_write_wb,
    output mem_to_reg_e, mem_to_reg_m,
    output branch_d, jump_d, link_d, hilo_d,
    output md_start_e, md_div_e, perf_clr,
    input  stall_f, stall_d, flush_e,
    input  forwardA_d, forwardB_d,
    input  forwardA_e, forwardB_e,
    input  forward_jr_f, forward_jalr_f,
    input  md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e,
    input  write_reg_e, write_reg_m, write_reg_wb,
    input  reg_write_e, reg_write_m, reg_write_wb,
    input  mem_to_reg_e, mem_to_reg_m,
    input  branch_d, jump_d, link_d, hilo_d,
    input  md_start_e, md_div_e, perf_clr,
    output stall_f, stall_d, flush_e,
    output forwardA_d, forwardB_d,
    output forwardA_e, forwardB_e,
    output forward_jr_f, forward_jalr_f,
    output md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// MIPS32 hazard unit: forwarding, load/HI-LO/branch stalls,
// multi-cycle MDU scoreboard and saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6,
  parameter int PERF_W   = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave hz
);
  localparam logic [REG_W-1:0] R0 = {REG_W{1'b0}};

  logic [CNT_W-1:0] md_cnt;
  logic hit_e, hit_m, dep_e, dep_m;
  logic lw_stall, mf_stall, br_stall, md_stall;
  logic stall;

  function automatic logic [1:0] fwd_e(
    input logic [REG_W-1:0] src
  );
    if (src != R0 && hz.reg_write_m &&
        src == hz.write_reg_m)
      return 2'b10;
    else if (src != R0 && hz.reg_write_wb &&
             src == hz.write_reg_wb)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.forwardA_e = fwd_e(hz.rs_e);
  assign hz.forwardB_e = fwd_e(hz.rt_e);

  assign hz.forwardA_d = hz.rs_d != R0 &&
    hz.reg_write_m && hz.rs_d == hz.write_reg_m;
  assign hz.forwardB_d = hz.rt_d != R0 &&
    hz.reg_write_m && hz.rt_d == hz.write_reg_m;

  assign hit_e = hz.rs_d == hz.write_reg_e ||
                 hz.rt_d == hz.write_reg_e;
  assign hit_m = hz.rs_d == hz.write_reg_m ||
                 hz.rt_d == hz.write_reg_m;
  assign dep_e = hz.reg_write_e &&
    hz.write_reg_e != R0 && hit_e;
  assign dep_m = hz.mem_to_reg_m != 2'b00 &&
    hz.write_reg_m != R0 && hit_m;

  assign lw_stall = hz.mem_to_reg_e == 2'b01 && dep_e;
  assign mf_stall = hz.mem_to_reg_e[1] && dep_e;
  assign br_stall = hz.branch_d != 3'b000 &&
    (dep_e || dep_m);
  // start cycle stalls too: counter is not loaded yet
  assign md_stall = hz.hilo_d &&
    (hz.md_busy || hz.md_start_e);

  assign stall = lw_stall | mf_stall |
                 br_stall | md_stall;
  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_e = stall;

  assign hz.forward_jr_f = hz.jump_d == 2'b10 &&
    !hz.link_d && hz.mem_to_reg_m == 2'b01 &&
    hz.rs_d == hz.write_reg_m && hz.rs_d != R0;
  assign hz.forward_jalr_f = hz.jump_d == 2'b10 &&
    hz.link_d && hz.reg_write_e &&
    hz.rs_d == hz.write_reg_e && hz.rs_d != R0;

  assign hz.md_busy = md_cnt != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt     <= '0;
      hz.md_done <= 1'b0;
    end else begin
      if (md_cnt == '0 && hz.md_start_e)
        md_cnt <= hz.md_div_e ? CNT_W'(DIV_LAT)
                              : CNT_W'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
      hz.md_done <= md_cnt == CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hz.stall_cnt <= '0;
    else if (hz.perf_clr)
      hz.stall_cnt <= '0;
    else if (stall && hz.stall_cnt != {PERF_W{1'b1}})
      hz.stall_cnt <= hz.stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed + random bench for hazard_scoreboard_unit against
// a cycle-timestamp reference model (PERF_W=4 for saturation).
module tb_hazard_scoreboard_unit;
  localparam int PW = 4;
  localparam int ML = 4;
  localparam int DL = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  // model state: MDU op end cycle, stall counter
  int cyc = 0;
  bit md_valid = 0;
  int md_end = 0;
  int m_scnt = 0;

  hazard_scoreboard_unit_if #(.REG_W(5), .PERF_W(PW)) hz();

  hazard_scoreboard_unit #(
    .REG_W(5), .MULT_LAT(ML), .DIV_LAT(DL),
    .CNT_W(6), .PERF_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return md_valid && cyc <= md_end;
  endfunction

  function automatic bit m_done();
    return md_valid && cyc == md_end + 1;
  endfunction

  function automatic bit reads(input logic [4:0] w);
    return hz.rs_d == w || hz.rt_d == w;
  endfunction

  function automatic bit m_stall();
    bit e_dep, m_dep;
    e_dep = hz.reg_write_e && hz.write_reg_e != 0 &&
            reads(hz.write_reg_e);
    m_dep = hz.mem_to_reg_m != 0 && hz.write_reg_m != 0 &&
            reads(hz.write_reg_m);
    if (hz.mem_to_reg_e == 2'b01 && e_dep) return 1;
    if (hz.mem_to_reg_e >= 2'b10 && e_dep) return 1;
    if (hz.branch_d != 0 && (e_dep || m_dep)) return 1;
    if (hz.hilo_d && (m_busy() || hz.md_start_e)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fe(input logic [4:0] s);
    if (s == 0) return 2'b00;
    if (hz.reg_write_m && s == hz.write_reg_m) return 2'b10;
    if (hz.reg_write_wb && s == hz.write_reg_wb) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_fd(input logic [4:0] s);
    return s != 0 && hz.reg_write_m && s == hz.write_reg_m;
  endfunction

  task automatic check_all();
    bit s;
    s = m_stall();
    chk("stall_f", hz.stall_f, s);
    chk("stall_d", hz.stall_d, s);
    chk("flush_e", hz.flush_e, s);
    chk("fwdA_d", hz.forwardA_d, m_fd(hz.rs_d));
    chk("fwdB_d", hz.forwardB_d, m_fd(hz.rt_d));
    chk("fwdA_e", hz.forwardA_e, m_fe(hz.rs_e));
    chk("fwdB_e", hz.forwardB_e, m_fe(hz.rt_e));
    chk("fwd_jr", hz.forward_jr_f,
        hz.jump_d == 2 && !hz.link_d &&
        hz.mem_to_reg_m == 1 && hz.rs_d == hz.write_reg_m &&
        hz.rs_d != 0);
    chk("fwd_jalr", hz.forward_jalr_f,
        hz.jump_d == 2 && hz.link_d && hz.reg_write_e &&
        hz.rs_d == hz.write_reg_e && hz.rs_d != 0);
    chk("md_busy", hz.md_busy, m_busy());
    chk("md_done", hz.md_done, m_done());
    chk("stall_cnt", hz.stall_cnt, m_scnt);
  endtask

  task automatic model_reset();
    md_valid = 0;
    m_scnt = 0;
  endtask

  // inputs are driven at negedge; compare, then advance model
  task automatic step();
    bit s;
    #1;
    check_all();
    s = m_stall();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (hz.md_start_e && !m_busy()) begin
        md_valid = 1;
        md_end = cyc + (hz.md_div_e ? DL : ML);
      end
      if (hz.perf_clr) m_scnt = 0;
      else if (s && m_scnt < (1 << PW) - 1) m_scnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    hz.rs_d = 0; hz.rt_d = 0; hz.rs_e = 0; hz.rt_e = 0;
    hz.write_reg_e = 0; hz.write_reg_m = 0;
    hz.write_reg_wb = 0;
    hz.reg_write_e = 0; hz.reg_write_m = 0;
    hz.reg_write_wb = 0;
    hz.mem_to_reg_e = 0; hz.mem_to_reg_m = 0;
    hz.branch_d = 0; hz.jump_d = 0; hz.link_d = 0;
    hz.hilo_d = 0; hz.md_start_e = 0; hz.md_div_e = 0;
    hz.perf_clr = 0;
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", hz.md_busy, 0);
    chk("rst_done", hz.md_done, 0);
    chk("rst_scnt", hz.stall_cnt, 0);
    rst = 1'b0;
    step();

    // load-use
    hz.mem_to_reg_e = 2'b01; hz.reg_write_e = 1;
    hz.write_reg_e = 8; hz.rs_d = 8;
    #1 chk("lw_stall", hz.stall_d, 1);
    step();
    hz.rs_d = 0; hz.write_reg_e = 0;
    #1 chk("lw_r0", hz.stall_d, 0);
    step();

    // E forwarding priority
    idle();
    hz.write_reg_m = 5; hz.reg_write_m = 1;
    hz.write_reg_wb = 5; hz.reg_write_wb = 1;
    hz.rs_e = 5;
    #1 chk("fwd_m", hz.forwardA_e, 2'b10);
    step();
    hz.reg_write_m = 0;
    #1 chk("fwd_wb", hz.forwardA_e, 2'b01);
    step();
    hz.rs_e = 0;
    #1 chk("fwd_rf", hz.forwardA_e, 2'b00);
    step();

    // mult with mfhi waiting in D
    idle();
    hz.hilo_d = 1; hz.md_start_e = 1;
    step();
    hz.md_start_e = 0;
    for (int i = 0; i < ML; i++) begin
      chk("mul_busy", hz.md_busy, 1);
      step();
    end
    chk("mul_done", hz.md_done, 1);
    chk("mul_free", hz.stall_d, 0);
    step();
    chk("mul_pulse", hz.md_done, 0);
    step();

    // div abandoned by reset at count 17
    idle();
    hz.md_start_e = 1; hz.md_div_e = 1;
    step();
    hz.md_start_e = 0;
    repeat (DL - 17) step();
    rst = 1'b1;
    model_reset();
    #1 chk("arst_busy", hz.md_busy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("arst_nodone", hz.md_done, 0);
      step();
    end
    hz.md_start_e = 1; hz.md_div_e = 1;
    step();
    hz.md_start_e = 0;
    repeat (DL) step();
    chk("div_done", hz.md_done, 1);
    // back-to-back: start on the count-zero cycle
    hz.md_start_e = 1; hz.md_div_e = 0;
    step();
    hz.md_start_e = 0;
    chk("b2b_busy", hz.md_busy, 1);
    repeat (ML + 1) step();

    // branch / jump-register cases
    idle();
    hz.branch_d = 3'b001; hz.reg_write_e = 1;
    hz.write_reg_e = 9; hz.rs_d = 9;
    #1 chk("br_stall", hz.stall_d, 1);
    step();
    hz.branch_d = 0; hz.jump_d = 2'b10; hz.link_d = 1;
    #1 chk("jalr_fwd", hz.forward_jalr_f, 1);
    step();
    idle();
    hz.jump_d = 2'b10; hz.mem_to_reg_m = 2'b01;
    hz.write_reg_m = 31; hz.rs_d = 31;
    #1 chk("jr_fwd", hz.forward_jr_f, 1);
    step();

    // stall counter saturation and clear priority
    idle();
    hz.perf_clr = 1;
    step();
    hz.perf_clr = 0;
    hz.mem_to_reg_e = 2'b01; hz.reg_write_e = 1;
    hz.write_reg_e = 8; hz.rs_d = 8;
    repeat (20) step();
    chk("scnt_sat", hz.stall_cnt, 15);
    hz.perf_clr = 1;
    step();
    chk("scnt_clr", hz.stall_cnt, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      hz.rs_d = 5'($urandom_range(0, 3));
      hz.rt_d = 5'($urandom_range(0, 3));
      hz.rs_e = 5'($urandom_range(0, 3));
      hz.rt_e = 5'($urandom_range(0, 3));
      hz.write_reg_e = 5'($urandom_range(0, 3));
      hz.write_reg_m = 5'($urandom_range(0, 3));
      hz.write_reg_wb = 5'($urandom_range(0, 3));
      hz.reg_write_e = 1'($urandom);
      hz.reg_write_m = 1'($urandom);
      hz.reg_write_wb = 1'($urandom);
      hz.mem_to_reg_e = 2'($urandom);
      hz.mem_to_reg_m = 2'($urandom);
      hz.branch_d = ($urandom_range(0, 3) == 0) ?
                    3'($urandom) : 3'd0;
      hz.jump_d = 2'($urandom);
      hz.link_d = 1'($urandom);
      hz.hilo_d = 1'($urandom);
      hz.md_start_e = $urandom_range(0, 7) == 0;
      hz.md_div_e = $urandom_range(0, 3) == 0;
      hz.perf_clr = $urandom_range(0, 15) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
